ex_muldiv: RTL

- Iterative RV32M multiply/divide unit on the consumer side of the ID/EX register.
- Takes ALU operands plus the destination register, runs a radix-2 multi-cycle computation and holds the pipeline through a stall request.
- Delivers one registered write-back beat when the computation finishes.
- Sits beside the single-cycle ALU in EX; its result is muxed into the EX/MEM write path while done is high.

---
 rtl/ex_muldiv.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one iteration per cycle, with a single registered write-back beat.
module ex_muldiv #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ITER       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [XLEN-1:0]       r1_data,
    input  logic [XLEN-1:0]       r2_data,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  done,
    output logic [XLEN-1:0]       result,
    output logic                  w_enable,
    output logic [REG_ADDR_W-1:0] w_addr
);

    localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       opnd_q, opnd_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  neg_q, neg_d;
    logic                  done_q, done_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;

    // Operand decode for the incoming op
    logic            is_div, is_rem, rs1_signed, rs2_signed, s1, s2;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, fast_result;

    assign is_div     = op[2];
    assign is_rem     = op[2] & op[1];
    assign rs1_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    assign rs2_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
    assign s1         = rs1_signed & r1_data[XLEN-1];
    assign s2         = rs2_signed & r2_data[XLEN-1];
    assign mag1       = s1 ? -r1_data : r1_data;
    assign mag2       = s2 ? -r2_data : r2_data;
    assign div_zero   = is_div & (r2_data == '0);
    assign div_ovf    = is_div & ~op[0] & (r1_data == {1'b1, {(XLEN-1){1'b0}}}) &
                        (r2_data == '1);
    assign fast_result = div_zero ? (is_rem ? r1_data : '1)
                                  : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration: acc holds {product_hi, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic              qbit;
    logic [2*XLEN-1:0] mul_next, div_next, step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, opnd_q} & {(XLEN+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opnd_q};
    assign qbit     = ~div_diff[XLEN];
    assign div_next = {(qbit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], qbit};
    assign step     = op_q[2] ? div_next : mul_next;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo, rem, final_result;

    assign prod_s = neg_q ? -step : step;
    assign quo    = step[XLEN-1:0];
    assign rem    = step[2*XLEN-1:XLEN];

    always_comb begin
        final_result = '0;
        case (op_q)
            3'd0:             final_result = step[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_result = neg_q ? -quo : quo;
            default:          final_result = neg_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        result_d  = result_q;
        w_addr_d  = w_addr_q;
        stall_req = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    stall_req = 1'b1;
                    op_d      = op;
                    addr_d    = w_addr_i;
                    neg_d     = is_rem ? s1 : (s1 ^ s2);
                    opnd_d    = is_div ? mag2 : mag1;
                    acc_d     = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                    cnt_d     = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = fast_result;
                        w_addr_d = w_addr_i;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Flush releases the pipeline in the same cycle it is raised
                stall_req = ~flush;
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(ITER - 1)) begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        result_d = final_result;
                        w_addr_d = addr_q;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            addr_q   <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            w_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
            result_q <= result_d;
            w_addr_q <= w_addr_d;
        end
    end

    assign done     = done_q;
    assign w_enable = done_q;
    assign result   = result_q;
    assign w_addr   = w_addr_q;

endmodule
